dircc_debug_cmd_sync: RTL and testbench
=======================================

// Module: dircc_debug_cmd_sync
// PURPOSE
//  System-clock half of the node debug slave, generalized. Synchronizes the virtual-JTAG update-DR/IR
//  strobes from the TCK domain and captures the shifted DR word and IR per update-DR. Presents each
//  command as a valid/ready transfer plus one-cycle per-IR take_action / take_no_action pulses.
//  Sits between the TCK-domain shift logic and the CPU debug/OCI logic.
// PARAMETERS
//  DATA_W       38  width of shift register sr / captured cmd_data
//  IR_W         2   virtual IR width; pulse vectors are 2**IR_W wide
//  SYNC_STAGES  2   synchronizer flops per async strobe, >=2
//  ACTION_BIT   34  sr bit selecting take_action (1) vs take_no_action (0); < DATA_W-1
//  CNT_W        8   width of saturating error counters
// PORTS
//  clk              in   1          system clock
//  reset            in   1          synchronous, active-high reset
//  udr_async        in   1          update-DR level from TCK domain
//  uir_async        in   1          update-IR level from TCK domain
//  ir_in            in   IR_W       virtual IR, stable around udr
//  sr               in   DATA_W     DR shift register, stable around udr
//  cmd_valid        out  1          captured command available
//  cmd_ready        in   1          consumer accepts command
//  cmd_ir           out  IR_W       IR of held command
//  cmd_data         out  DATA_W     sr of held command (jdo)
//  take_action      out  2**IR_W    one-cycle pulse, bit = cmd IR, sr[ACTION_BIT]=1
//  take_no_action   out  2**IR_W    one-cycle pulse, bit = cmd IR, sr[ACTION_BIT]=0
//  ir_update        out  1          one-cycle pulse per synchronized uir rising edge
//  overrun_cnt      out  CNT_W      commands dropped while holding, saturating
//  parity_err_cnt   out  CNT_W      commands discarded on bad parity, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, sync chains 0, armed=0 (both strobes).
//  - Sync: s[0]<=async, s[i]<=s[i-1]; d<=s[S-1]; edge = s[S-1] & ~d & armed.
//  - armed set once s[S-1]==0 observed after reset; strobe high across reset makes no command.
//  - udr edge -> capture {ir_in,sr}; outputs update next clk: latency SYNC_STAGES+1 from async rise.
//  - FSM IDLE: udr edge -> HOLD, cmd_valid=1, cmd_ir/cmd_data loaded, one pulse bit set same cycle.
//  - FSM HOLD: cmd_valid, cmd_ir, cmd_data stable; cmd_valid&cmd_ready -> IDLE, cmd_valid=0 next clk.
//  - HOLD + udr edge + no handshake: new command dropped, overrun_cnt+1, no pulse.
//  - HOLD + udr edge + handshake same cycle: new command captured back-to-back, stay HOLD, pulse issued.
//  - Pulses never assert for a dropped/discarded command; only one bit of either vector high at a time.
//  - uir edge -> ir_update pulse next clk; independent of FSM; no effect on held command.
//  - Counters saturate at 2**CNT_W-1; cleared only by reset.
//  - Reset mid-HOLD: command lost, cmd_valid=0 next clk, no pulse.
// CONFIGURATION
//  DIRCC_DBG_PARITY_EN defined: sr[DATA_W-1] = even parity over sr[DATA_W-2:0].
//    Mismatch on capture: command discarded, no FSM change, no pulse, parity_err_cnt+1.
//    The parity check runs before the overrun check; a bad-parity word never counts as overrun.
//  Not defined: no check; sr[DATA_W-1] is ordinary data; parity_err_cnt tied 0.
// TESTING (defaults, SYNC_STAGES=2)
//  1 udr 0->1, ir=2, sr[34]=1 -> 3 clks later cmd_valid=1, cmd_ir=2, take_action=4'b0100 for 1 clk
//  2 ready held 0, second udr edge -> overrun_cnt=1, cmd_data unchanged, no pulse; ready=1 -> valid=0
//  3 udr edge synchronized on same clk as handshake -> cmd_valid stays 1, new data, 1 pulse, cnt 0
//  4 udr_async=1 through reset release -> no command until udr falls and rises again
//  5 PARITY_EN: sr with odd parity -> parity_err_cnt=1, cmd_valid=0, no pulse; good parity -> accepted
//  6 overrun 300 times with CNT_W=8 -> overrun_cnt=255; reset mid-HOLD -> cmd_valid=0, cnt=0

Source files
------------

// File: rtl/dircc_debug_cmd_sync.sv
// dircc_debug_cmd_sync
//   System-clock half of the node debug slave. Brings the virtual-JTAG
//   update-DR / update-IR strobes over from the TCK domain, captures
//   {ir_in, sr} on each synchronized update-DR rising edge, and presents
//   the command as a valid/ready transfer with a one-cycle take_action /
//   take_no_action pulse on the bit selected by the command IR.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   udr_async         update-DR level (TCK domain)
//   uir_async         update-IR level (TCK domain)
//   ir_in, sr         virtual IR and DR shift word, stable around update-DR
//   cmd_valid/ready   command handshake; cmd_ir/cmd_data held while valid
//   take_action       one-cycle pulse, bit cmd_ir, when sr[ACTION_BIT]=1
//   take_no_action    one-cycle pulse, bit cmd_ir, when sr[ACTION_BIT]=0
//   ir_update         one-cycle pulse per synchronized update-IR rise
//   overrun_cnt       saturating count of commands dropped while holding
//   parity_err_cnt    saturating count of commands discarded on bad parity
//
// Build option
//   DIRCC_DBG_PARITY_EN : sr[DATA_W-1] is even parity over sr[DATA_W-2:0];
//                         mismatching words are discarded and counted.
//                         Undefined: no check, parity_err_cnt stays 0.

module dircc_debug_cmd_sync #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACTION_BIT  = 34,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   udr_async,
    input  logic                   uir_async,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [DATA_W-1:0]      sr,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [IR_W-1:0]        cmd_ir,
    output logic [DATA_W-1:0]      cmd_data,
    output logic [(1<<IR_W)-1:0]   take_action,
    output logic [(1<<IR_W)-1:0]   take_no_action,
    output logic                   ir_update,
    output logic [CNT_W-1:0]       overrun_cnt,
    output logic [CNT_W-1:0]       parity_err_cnt
);

    localparam int unsigned NV = 1 << IR_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] udr_s_q, udr_s_d;
    logic [SYNC_STAGES-1:0] uir_s_q, uir_s_d;
    // Marks which sync stages hold a real sample rather than the reset value.
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   udr_dly_q, udr_dly_d;
    logic                   uir_dly_q, uir_dly_d;
    logic                   udr_armed_q, udr_armed_d;
    logic                   uir_armed_q, uir_armed_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
    logic [DATA_W-1:0]      cmd_data_q, cmd_data_d;
    logic [NV-1:0]          take_action_q, take_action_d;
    logic [NV-1:0]          take_no_action_q, take_no_action_d;
    logic                   ir_update_q, ir_update_d;
    logic [CNT_W-1:0]       overrun_cnt_q, overrun_cnt_d;
    logic [CNT_W-1:0]       parity_err_cnt_q, parity_err_cnt_d;

    logic udr_edge, uir_edge, handshake, load, parity_ok;

`ifdef DIRCC_DBG_PARITY_EN
    // Even parity over the whole word, parity bit included, XORs to zero.
    assign parity_ok = ~(^sr);
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        udr_s_d = {udr_s_q[SYNC_STAGES-2:0], udr_async};
        uir_s_d = {uir_s_q[SYNC_STAGES-2:0], uir_async};
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};

        udr_dly_d = udr_s_q[SYNC_STAGES-1];
        uir_dly_d = uir_s_q[SYNC_STAGES-1];

        // Arm only after a genuine low sample, so a strobe held high across
        // reset cannot be mistaken for a fresh rising edge.
        udr_armed_d = udr_armed_q | (vld_q[SYNC_STAGES-1] & ~udr_s_q[SYNC_STAGES-1]);
        uir_armed_d = uir_armed_q | (vld_q[SYNC_STAGES-1] & ~uir_s_q[SYNC_STAGES-1]);

        udr_edge = udr_s_q[SYNC_STAGES-1] & ~udr_dly_q & udr_armed_q;
        uir_edge = uir_s_q[SYNC_STAGES-1] & ~uir_dly_q & uir_armed_q;

        state_d          = state_q;
        cmd_valid_d      = cmd_valid_q;
        cmd_ir_d         = cmd_ir_q;
        cmd_data_d       = cmd_data_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        ir_update_d      = uir_edge;
        overrun_cnt_d    = overrun_cnt_q;
        parity_err_cnt_d = parity_err_cnt_q;

        handshake = cmd_valid_q & cmd_ready;
        load      = 1'b0;

        // Parity is judged first so a bad word is never counted as overrun.
        if (udr_edge && !parity_ok) begin
            if (parity_err_cnt_q != '1)
                parity_err_cnt_d = parity_err_cnt_q + CNT_W'(1);
        end else if (udr_edge && (state_q == IDLE || handshake)) begin
            load = 1'b1;
        end else if (udr_edge) begin
            if (overrun_cnt_q != '1)
                overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
        end

        if (load) begin
            state_d     = HOLD;
            cmd_valid_d = 1'b1;
            cmd_ir_d    = ir_in;
            cmd_data_d  = sr;
            take_action_d[ir_in]    = sr[ACTION_BIT];
            take_no_action_d[ir_in] = ~sr[ACTION_BIT];
        end else if (handshake) begin
            state_d     = IDLE;
            cmd_valid_d = 1'b0;
        end

`ifndef DIRCC_DBG_PARITY_EN
        parity_err_cnt_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            udr_s_q          <= '0;
            uir_s_q          <= '0;
            vld_q            <= '0;
            udr_dly_q        <= 1'b0;
            uir_dly_q        <= 1'b0;
            udr_armed_q      <= 1'b0;
            uir_armed_q      <= 1'b0;
            cmd_valid_q      <= 1'b0;
            cmd_ir_q         <= '0;
            cmd_data_q       <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            ir_update_q      <= 1'b0;
            overrun_cnt_q    <= '0;
            parity_err_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            udr_s_q          <= udr_s_d;
            uir_s_q          <= uir_s_d;
            vld_q            <= vld_d;
            udr_dly_q        <= udr_dly_d;
            uir_dly_q        <= uir_dly_d;
            udr_armed_q      <= udr_armed_d;
            uir_armed_q      <= uir_armed_d;
            cmd_valid_q      <= cmd_valid_d;
            cmd_ir_q         <= cmd_ir_d;
            cmd_data_q       <= cmd_data_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            ir_update_q      <= ir_update_d;
            overrun_cnt_q    <= overrun_cnt_d;
            parity_err_cnt_q <= parity_err_cnt_d;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_ir         = cmd_ir_q;
    assign cmd_data       = cmd_data_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign ir_update      = ir_update_q;
    assign overrun_cnt    = overrun_cnt_q;
    assign parity_err_cnt = parity_err_cnt_q;

endmodule

// File: tb/tb_dircc_debug_cmd_sync.sv
// Testbench for dircc_debug_cmd_sync (default parameters, SYNC_STAGES=2).
// Table-driven cycle vectors, hand sequences for reset/overrun/parity corner
// cases, then randomized traffic against a transaction-level reference model.

module tb_dircc_debug_cmd_sync;

    localparam int DW = 38;
    localparam int IW = 2;
    localparam int S  = 2;
    localparam int AB = 34;
    localparam int CW = 8;
    localparam int NR = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          udr_async, uir_async, cmd_ready;
    logic [IW-1:0] ir_in;
    logic [DW-1:0] sr;
    logic          cmd_valid;
    logic [IW-1:0] cmd_ir;
    logic [DW-1:0] cmd_data;
    logic [3:0]    take_action, take_no_action;
    logic          ir_update;
    logic [CW-1:0] overrun_cnt, parity_err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dircc_debug_cmd_sync #(
        .DATA_W(DW), .IR_W(IW), .SYNC_STAGES(S), .ACTION_BIT(AB), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .udr_async(udr_async), .uir_async(uir_async),
        .ir_in(ir_in), .sr(sr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .take_action(take_action), .take_no_action(take_no_action),
        .ir_update(ir_update),
        .overrun_cnt(overrun_cnt), .parity_err_cnt(parity_err_cnt)
    );

    typedef struct {
        logic          udr, uir, rdy;
        logic [IW-1:0] ir;
        logic [DW-1:0] sr;
        logic          ev;
        logic [IW-1:0] eir;
        logic [DW-1:0] ed;
        logic [3:0]    eta, etna;
        logic          eiru;
        logic [CW-1:0] eovr;
    } vec_t;

    vec_t tv[20];

    localparam logic [DW-1:0] A = 38'h04_0000_1234; // bit 34 = 1
    localparam logic [DW-1:0] B = 38'h00_0000_5678; // bit 34 = 0
    localparam logic [DW-1:0] C = 38'h3B_CAFE_0001; // bit 34 = 0

    function automatic vec_t mk(input logic udr, uir, rdy, input logic [IW-1:0] ir,
                                input logic [DW-1:0] s, input logic ev,
                                input logic [IW-1:0] eir, input logic [DW-1:0] ed,
                                input logic [3:0] eta, etna, input logic eiru,
                                input logic [CW-1:0] eovr);
        vec_t v;
        v.udr = udr; v.uir = uir; v.rdy = rdy; v.ir = ir; v.sr = s;
        v.ev = ev; v.eir = eir; v.ed = ed; v.eta = eta; v.etna = etna;
        v.eiru = eiru; v.eovr = eovr;
        return v;
    endfunction

    // Makes a word carry correct even parity when the parity build is used.
    function automatic logic [DW-1:0] fixp(input logic [DW-1:0] x);
`ifdef DIRCC_DBG_PARITY_EN
        return {^x[DW-2:0], x[DW-2:0]};
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model state (random phase).
    logic          m_valid;
    logic [IW-1:0] m_ir;
    logic [DW-1:0] m_data;
    logic [3:0]    m_ta, m_tna;
    logic          m_iru;
    int            m_ovr, m_perr;
    logic          hu[0:NR+16];
    logic          hi[0:NR+16];
    logic [DW-1:0] rsr;
    logic          ev_now, hs, badp;

    initial begin
        reset = 1'b1; udr_async = 1'b0; uir_async = 1'b0; cmd_ready = 1'b0;
        ir_in = '0; sr = '0;

        tv[0]  = mk(1,0,0,2,A, 0,0,'0,4'b0000,4'b0000,0,0);
        tv[1]  = mk(1,0,0,2,A, 0,0,'0,4'b0000,4'b0000,0,0);
        tv[2]  = mk(1,0,0,2,A, 1,2,A, 4'b0100,4'b0000,0,0);
        tv[3]  = mk(0,1,0,2,A, 1,2,A, 4'b0000,4'b0000,0,0);
        tv[4]  = mk(0,0,0,2,A, 1,2,A, 4'b0000,4'b0000,0,0);
        tv[5]  = mk(1,0,0,1,B, 1,2,A, 4'b0000,4'b0000,1,0);
        tv[6]  = mk(1,0,0,1,B, 1,2,A, 4'b0000,4'b0000,0,0);
        tv[7]  = mk(1,0,0,1,B, 1,2,A, 4'b0000,4'b0000,0,1);
        tv[8]  = mk(0,0,1,1,B, 0,0,'0,4'b0000,4'b0000,0,1);
        tv[9]  = mk(0,0,0,1,B, 0,0,'0,4'b0000,4'b0000,0,1);
        tv[10] = mk(1,0,0,0,B, 0,0,'0,4'b0000,4'b0000,0,1);
        tv[11] = mk(1,0,0,0,B, 0,0,'0,4'b0000,4'b0000,0,1);
        tv[12] = mk(1,0,0,0,B, 1,0,B, 4'b0000,4'b0001,0,1);
        tv[13] = mk(0,0,0,0,B, 1,0,B, 4'b0000,4'b0000,0,1);
        tv[14] = mk(1,0,0,3,C, 1,0,B, 4'b0000,4'b0000,0,1);
        tv[15] = mk(1,0,0,3,C, 1,0,B, 4'b0000,4'b0000,0,1);
        tv[16] = mk(1,0,1,3,C, 1,3,C, 4'b0000,4'b1000,0,1);
        tv[17] = mk(0,0,0,3,C, 1,3,C, 4'b0000,4'b0000,0,1);
        tv[18] = mk(0,0,1,3,C, 0,0,'0,4'b0000,4'b0000,0,1);
        tv[19] = mk(0,0,0,3,C, 0,0,'0,4'b0000,4'b0000,0,1);

        // Reset state
        repeat (3) step();
        chk("rst_valid", 64'(cmd_valid), 64'(0));
        chk("rst_ir", 64'(cmd_ir), 64'(0));
        chk("rst_data", 64'(cmd_data), 64'(0));
        chk("rst_ta", 64'(take_action), 64'(0));
        chk("rst_tna", 64'(take_no_action), 64'(0));
        chk("rst_iru", 64'(ir_update), 64'(0));
        chk("rst_ovr", 64'(overrun_cnt), 64'(0));
        chk("rst_perr", 64'(parity_err_cnt), 64'(0));
        reset = 1'b0;
        repeat (6) step();

        // Table: first command, overrun, back-to-back capture on handshake
        for (int i = 0; i < 20; i++) begin
            udr_async = tv[i].udr; uir_async = tv[i].uir; cmd_ready = tv[i].rdy;
            ir_in = tv[i].ir; sr = fixp(tv[i].sr);
            step();
            chk($sformatf("tv%0d_valid", i), 64'(cmd_valid), 64'(tv[i].ev));
            if (tv[i].ev) begin
                chk($sformatf("tv%0d_ir", i), 64'(cmd_ir), 64'(tv[i].eir));
                chk($sformatf("tv%0d_data", i), 64'(cmd_data), 64'(fixp(tv[i].ed)));
            end
            chk($sformatf("tv%0d_ta", i), 64'(take_action), 64'(tv[i].eta));
            chk($sformatf("tv%0d_tna", i), 64'(take_no_action), 64'(tv[i].etna));
            chk($sformatf("tv%0d_iru", i), 64'(ir_update), 64'(tv[i].eiru));
            chk($sformatf("tv%0d_ovr", i), 64'(overrun_cnt), 64'(tv[i].eovr));
        end
        udr_async = 1'b0; uir_async = 1'b0; cmd_ready = 1'b0;

        // Strobe held high across reset release: no command until it re-rises
        reset = 1'b1; udr_async = 1'b1; ir_in = 2'd1; sr = fixp(A);
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("hi_rst_valid%0d", i), 64'(cmd_valid), 64'(0));
        end
        udr_async = 1'b0;
        repeat (4) step();
        udr_async = 1'b1;
        repeat (3) step();
        chk("rearm_valid", 64'(cmd_valid), 64'(1));
        chk("rearm_ir", 64'(cmd_ir), 64'(1));
        chk("rearm_ta", 64'(take_action), 64'(4'b0010));
        udr_async = 1'b0; cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("rearm_drain", 64'(cmd_valid), 64'(0));

        // Overrun saturation, then reset mid-HOLD
        udr_async = 1'b1; ir_in = 2'd0; sr = fixp(B);
        step();
        udr_async = 1'b0;
        repeat (3) step();
        chk("sat_hold_valid", 64'(cmd_valid), 64'(1));
        sr = fixp(C);
        for (int i = 0; i < 300; i++) begin
            udr_async = 1'b1; step();
            udr_async = 1'b0; step();
        end
        repeat (3) step();
        chk("sat_ovr", 64'(overrun_cnt), 64'(255));
        chk("sat_valid", 64'(cmd_valid), 64'(1));
        chk("sat_data", 64'(cmd_data), 64'(fixp(B)));
        reset = 1'b1;
        step();
        chk("midrst_valid", 64'(cmd_valid), 64'(0));
        chk("midrst_ovr", 64'(overrun_cnt), 64'(0));
        chk("midrst_tna", 64'(take_no_action), 64'(0));
        reset = 1'b0;
        repeat (6) step();

`ifdef DIRCC_DBG_PARITY_EN
        // Bad parity discarded and counted; good parity accepted
        udr_async = 1'b1; ir_in = 2'd2; sr = fixp(A) ^ 38'h1;
        step();
        udr_async = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("par_bad_valid%0d", i), 64'(cmd_valid), 64'(0));
            chk($sformatf("par_bad_ta%0d", i), 64'(take_action), 64'(0));
        end
        chk("par_cnt1", 64'(parity_err_cnt), 64'(1));
        chk("par_bad_ovr", 64'(overrun_cnt), 64'(0));
        udr_async = 1'b1; sr = fixp(A);
        step();
        udr_async = 1'b0;
        step(); step();
        chk("par_good_valid", 64'(cmd_valid), 64'(1));
        chk("par_good_ta", 64'(take_action), 64'(4'b0100));
        chk("par_good_cnt", 64'(parity_err_cnt), 64'(1));
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
`else
        chk("perr_tied0", 64'(parity_err_cnt), 64'(0));
`endif

        // Randomized traffic against a transaction-level reference model
        reset = 1'b1; udr_async = 1'b0; uir_async = 1'b0; cmd_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin hu[k] = 1'b0; hi[k] = 1'b0; end
        repeat (7) step();
        m_valid = 1'b0; m_ir = '0; m_data = '0; m_ovr = 0; m_perr = 0;
        for (int m = 8; m < NR + 8; m++) begin
            if ($urandom_range(0, 2) == 0) udr_async = ~udr_async;
            if ($urandom_range(0, 3) == 0) uir_async = ~uir_async;
            cmd_ready = 1'($urandom_range(0, 1));
            ir_in = IW'($urandom_range(0, 3));
            rsr = DW'({$urandom(), $urandom()});
`ifdef DIRCC_DBG_PARITY_EN
            if ($urandom_range(0, 3) != 0) rsr = fixp(rsr);
`endif
            sr = rsr;
            hu[m] = udr_async; hi[m] = uir_async;
            @(posedge clk);
            // A rise presented at edge m-S becomes a command at edge m.
            ev_now = hu[m-S] & ~hu[m-S-1];
            m_iru  = hi[m-S] & ~hi[m-S-1];
            hs     = m_valid & cmd_ready;
`ifdef DIRCC_DBG_PARITY_EN
            badp = ($countones(rsr) % 2) != 0;
`else
            badp = 1'b0;
`endif
            m_ta = '0; m_tna = '0;
            if (ev_now && badp) begin
                if (m_perr < 255) m_perr++;
                if (hs) m_valid = 1'b0;
            end else if (ev_now && (!m_valid || hs)) begin
                m_valid = 1'b1; m_ir = ir_in; m_data = rsr;
                if (rsr[AB]) m_ta = 4'b0001 << ir_in;
                else m_tna = 4'b0001 << ir_in;
            end else if (ev_now) begin
                if (m_ovr < 255) m_ovr++;
            end else if (hs) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
            chk("rnd_valid", 64'(cmd_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rnd_ir", 64'(cmd_ir), 64'(m_ir));
                chk("rnd_data", 64'(cmd_data), 64'(m_data));
            end
            chk("rnd_ta", 64'(take_action), 64'(m_ta));
            chk("rnd_tna", 64'(take_no_action), 64'(m_tna));
            chk("rnd_iru", 64'(ir_update), 64'(m_iru));
            chk("rnd_ovr", 64'(overrun_cnt), 64'(m_ovr));
            chk("rnd_perr", 64'(parity_err_cnt), 64'(m_perr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
